// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep (chirp) sequencer feeding the DDS phase input.
// A start pulse captures the sweep configuration; the block then emits one
// phase word per clock, accumulating a tuning word that is stepped by a
// signed increment at the end of every dwell period.
module dds_sweep_ctrl #(
  parameter int PHASE_DW    = 16,
  parameter int STEP_CNT_DW = 16,
  parameter int DWELL_DW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_DW-1:0]    cfg_phase0,
  input  logic [PHASE_DW-1:0]    cfg_start_freq,
  input  logic [PHASE_DW-1:0]    cfg_freq_step,
  input  logic [STEP_CNT_DW-1:0] cfg_num_steps,
  input  logic [DWELL_DW-1:0]    cfg_dwell,
  input  logic                   cfg_loop,
  output logic [PHASE_DW-1:0]    m_axis_phase_tdata,
  output logic                   m_axis_phase_tvalid,
  output logic                   m_axis_phase_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_CNT_DW-1:0] step_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [STEP_CNT_DW-1:0] STEP_ONE  = STEP_CNT_DW'(1);
  localparam logic [DWELL_DW-1:0]    DWELL_ONE = DWELL_DW'(1);

  state_t state;
  state_t state_next;

  logic [PHASE_DW-1:0]    phase_acc;
  logic [PHASE_DW-1:0]    freq;
  logic [PHASE_DW-1:0]    start_freq_q;
  logic [PHASE_DW-1:0]    freq_step_q;
  logic [STEP_CNT_DW-1:0] num_steps_q;
  logic [STEP_CNT_DW-1:0] step_cnt;
  logic [DWELL_DW-1:0]    dwell_q;
  logic [DWELL_DW-1:0]    dwell_cnt;
  logic                   loop_q;

  logic accept_start;
  logic end_of_dwell;
  logic final_dwell;

  // Zero-valued count fields are stored as 1 at capture, so these compares never underflow.
  assign accept_start = (state == IDLE) && start;
  assign end_of_dwell = (dwell_cnt == (dwell_q - DWELL_ONE));
  assign final_dwell  = end_of_dwell && (step_cnt == (num_steps_q - STEP_ONE));

  assign m_axis_phase_tdata = phase_acc;
  assign step_index         = step_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs; stop takes priority over the final dwell.
  always_comb begin
    state_next          = state;
    m_axis_phase_tvalid = 1'b0;
    m_axis_phase_tlast  = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        m_axis_phase_tvalid = 1'b1;
        m_axis_phase_tlast  = final_dwell;
        busy                = 1'b1;
        if (stop) begin
          state_next = IDLE;
        end else if (final_dwell && !loop_q) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Configuration capture, phase accumulation and dwell/step counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_acc    <= '0;
      freq         <= '0;
      start_freq_q <= '0;
      freq_step_q  <= '0;
      num_steps_q  <= STEP_ONE;
      dwell_q      <= DWELL_ONE;
      loop_q       <= 1'b0;
      step_cnt     <= '0;
      dwell_cnt    <= '0;
    end else if (accept_start) begin
      phase_acc    <= cfg_phase0;
      freq         <= cfg_start_freq;
      start_freq_q <= cfg_start_freq;
      freq_step_q  <= cfg_freq_step;
      num_steps_q  <= (cfg_num_steps == '0) ? STEP_ONE : cfg_num_steps;
      dwell_q      <= (cfg_dwell == '0) ? DWELL_ONE : cfg_dwell;
      loop_q       <= cfg_loop;
      step_cnt     <= '0;
      dwell_cnt    <= '0;
    end else if ((state == RUN) && !stop) begin
      phase_acc <= phase_acc + freq;
      if (end_of_dwell) begin
        dwell_cnt <= '0;
        if (final_dwell && loop_q) begin
          freq     <= start_freq_q;
          step_cnt <= '0;
        end else begin
          freq     <= freq + freq_step_q;
          step_cnt <= step_cnt + STEP_ONE;
        end
      end else begin
        dwell_cnt <= dwell_cnt + DWELL_ONE;
      end
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep (chirp) sequencer that drives the phase input of the DDS block. A start pulse latches a sweep configuration, and the sequencer then emits one phase word per clock. The phase is accumulated from a frequency tuning word, and that word is stepped by a signed increment after every dwell period, for a programmed number of steps. The block sits directly upstream of the DDS `s_axis_phase_*` port and supports single-shot and continuous-loop sweeps.

## Interface
- `PHASE_DW`, 16: width of the phase word, tuning word and step; matches the DDS `PHASE_DW`.
- `STEP_CNT_DW`, 16: width of the step-count field.
- `DWELL_DW`, 16: width of the dwell-length field.

- `clk`  in  1: the single clock.
- `reset`  in  1: reset, synchronous and active-high.
- `start`  in  1: sweep start pulse; sampled only in IDLE.
- `stop`  in  1: abort request; takes effect in RUN.
- `cfg_phase0`  in  PHASE_DW: initial phase.
- `cfg_start_freq`  in  PHASE_DW: initial tuning word.
- `cfg_freq_step`  in  PHASE_DW: signed two's-complement step added to the tuning word.
- `cfg_num_steps`  in  STEP_CNT_DW: number of frequency steps; 0 is treated as 1.
- `cfg_dwell`  in  DWELL_DW: cycles per step; 0 is treated as 1.
- `cfg_loop`  in  1: 1 means restart the sweep instead of finishing.
- `m_axis_phase_tdata`  out  PHASE_DW: phase word to the DDS.
- `m_axis_phase_tvalid`  out  1: phase word valid.
- `m_axis_phase_tlast`  out  1: marks the last sample of each sweep pass.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse on normal completion.
- `step_index`  out  STEP_CNT_DW: index of the current step.

## Operation
- **States:** IDLE, RUN, DONE.
- **Configuration capture:** all `cfg_*` inputs are captured into shadow registers on an accepted start. They are ignored at all other times.
- **IDLE + start.** On this edge:
  - `phase_acc`←`cfg_phase0`, `freq`←`cfg_start_freq`.
  - `dwell_cnt`←0, `step_cnt`←0.
  - State→RUN.
- **RUN, every cycle:**
  - `phase_acc`←`phase_acc`+`freq`, modulo 2^PHASE_DW.
  - `dwell_cnt`++.
- **End of dwell.** When `dwell_cnt`==dwell−1:
  - `dwell_cnt`←0, `freq`←`freq`+step (wraps modulo 2^PHASE_DW, no saturation), `step_cnt`++.
- **Final dwell cycle.** When it is the end of dwell and `step_cnt`==num_steps−1:
  - If loop=1: `freq`←start_freq, `step_cnt`←0, stay in RUN. `phase_acc` continues without a reset (phase-continuous).
  - If loop=0: state→DONE.
- **DONE:** lasts exactly one cycle, then IDLE.
- **Outputs:**
  - `m_axis_phase_tdata` = `phase_acc`.
  - `m_axis_phase_tvalid` = (state==RUN).
  - `m_axis_phase_tlast` = RUN and final dwell cycle.
  - `busy` = (state==RUN).
  - `done` = (state==DONE).
  - `step_index` = `step_cnt`.
- **stop in RUN:** state→IDLE on the next edge. No `done` pulse, no `tlast`. Stop wins over a simultaneous final dwell cycle.
- **start when not in IDLE** (RUN or DONE): ignored. start+stop in IDLE: start is accepted.
- **Backpressure:** none; the DDS always accepts input. A sweep produces exactly num_steps×dwell valid samples.

## Timing
- **Reset:** state IDLE, and all outputs 0: tdata, tvalid, tlast, busy, done, step_index.
- **Reset mid-sweep:** same result as reset; no `done` pulse.
- **Start latency:** `start` sampled at edge N gives tvalid=1 from edge N on, with the first tdata = `cfg_phase0`.
- **Sweep length:** the last valid sample is at edge N+num_steps×dwell−1 with tlast=1. `done`=1 for the following cycle. tvalid is 0 from that cycle on.
- **Restart latency:** the earliest restart is the start sampled in the cycle after `done` (IDLE).
- **Step update:** a tuning-word change first affects the sample two cycles after the end-of-dwell edge. The sample immediately after the edge still used the old freq in its accumulation.
- **Abort latency:** `stop` sampled at edge M gives tvalid=0 from edge M on.

## Test plan
- **Basic sweep:** PHASE_DW=16, phase0=0, start_freq=0x0100, step=0x0100, steps=3, dwell=2, loop=0. Expect tdata 0x0000, 0x0100, 0x0200, 0x0400, 0x0600, 0x0900; tlast on 0x0900; `done` pulse next cycle; step_index 0,0,1,1,2,2.
- **Loop:** same configuration with loop=1. The second pass continues 0x0900+0x0300=0x0C00, then freq=0x0100: samples 0x0C00, 0x0D00, 0x0E00, …; tlast every 6 samples; no `done`.
- **Wrap / negative step:** start_freq=0x0010, step=0xFFF0 (−16), steps=3, dwell=1, phase0=0xFFF8. Expect tdata 0xFFF8, 0x0008, 0x0008; freq 0x0010, 0x0000, 0xFFF0.
- **Zero fields:** steps=0, dwell=0. Expect exactly one valid sample = phase0 with tlast, then `done`.
- **Abort:** stop asserted on the 3rd valid sample of the basic sweep. Expect tvalid=0 from that edge on; no `done`, no tlast; start ignored during RUN; a new start in IDLE restarts from phase0.
- **Reset mid-sweep:** reset on the 4th sample. Expect all outputs 0 next cycle and state IDLE; a later start produces the basic sequence exactly.
